fc_feature_sequencer: RTL and testbench

Front-end producer for the fully connected layer. Accepts a stream of signed feature-map samples from the pooling stage and assembles them into a flattened parallel buffer. It then issues a single-cycle start pulse to the FC layer and holds the buffer stable for the whole FC computation. It captures the FC scalar result and returns it to the downstream consumer over a valid/ready handshake.

---
 rtl/fc_feature_sequencer.sv | 115 +++++++++++
 tb/tb_fc_feature_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_feature_sequencer.sv
// Collects one flattened feature frame, launches the FC layer with a single-cycle start,
// and returns the FC result through a valid/ready handshake.
module fc_feature_sequencer #(
  parameter int DATA_W  = 22,
  parameter int N_FEAT  = 225,
  parameter int RES_W   = 48,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_flattened_data [0:N_FEAT-1],
  output logic                     o_fc_start,
  input  logic                     i_fc_result_valid,
  input  logic signed [RES_W-1:0]  i_fc_result_data,
  output logic                     o_result_valid,
  output logic signed [RES_W-1:0]  o_result_data,
  input  logic                     i_result_ready,
  output logic                     o_frame_err,
  output logic                     o_timeout
);

  localparam int CNT_W  = $clog2(N_FEAT);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_FEAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wr_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  assign o_ready = (state == S_FILL);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FILL;
      wr_cnt         <= '0;
      wait_cnt       <= '0;
      o_fc_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_result_data  <= '0;
      o_frame_err    <= 1'b0;
      o_timeout      <= 1'b0;
      // NOTE: the frame buffer is cleared on reset because the FC layer sees it
      // directly; this costs a reset fan-out on every entry, unlike a plain RAM.
      for (int i = 0; i < N_FEAT; i++) o_flattened_data[i] <= '0;
    end else begin
      o_fc_start  <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;

      unique case (state)
        S_FILL: begin
          if (i_valid) begin
            o_flattened_data[wr_cnt] <= i_data;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              if (i_last) begin
                state      <= S_LAUNCH;
                o_fc_start <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else if (i_last) begin
              // Short frame: discard and restart; stale entries get overwritten.
              wr_cnt      <= '0;
              o_frame_err <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end

        S_WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (i_fc_result_valid) begin
            o_result_data  <= i_fc_result_data;
            o_result_valid <= 1'b1;
            state          <= S_HOLD;
          end else if (wait_cnt == WAIT_LIM) begin
            o_timeout <= 1'b1;
            state     <= S_FILL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (o_result_valid && i_result_ready) begin
            o_result_valid <= 1'b0;
            state          <= S_FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_feature_sequencer.sv
// Directed bench for fc_feature_sequencer: frame fill, launch, result handshake,
// frame errors, timeout, HOLD back-pressure and mid-operation reset.
module tb_fc_feature_sequencer;

  localparam int DATA_W  = 22;
  localparam int N_FEAT  = 225;
  localparam int RES_W   = 48;
  localparam int TIMEOUT = 1023;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_valid;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_last;
  logic                     o_ready;
  logic signed [DATA_W-1:0] flat [0:N_FEAT-1];
  logic                     o_fc_start;
  logic                     i_fc_result_valid;
  logic signed [RES_W-1:0]  i_fc_result_data;
  logic                     o_result_valid;
  logic signed [RES_W-1:0]  o_result_data;
  logic                     i_result_ready;
  logic                     o_frame_err;
  logic                     o_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int rv_cnt = 0;

  fc_feature_sequencer #(
    .DATA_W(DATA_W), .N_FEAT(N_FEAT), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_valid          (i_valid),
    .i_data           (i_data),
    .i_last           (i_last),
    .o_ready          (o_ready),
    .o_flattened_data (flat),
    .o_fc_start       (o_fc_start),
    .i_fc_result_valid(i_fc_result_valid),
    .i_fc_result_data (i_fc_result_data),
    .o_result_valid   (o_result_valid),
    .o_result_data    (o_result_data),
    .i_result_ready   (i_result_ready),
    .o_frame_err      (o_frame_err),
    .o_timeout        (o_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_fc_start)     start_cnt++;
    if (o_result_valid) rv_cnt++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int base, input int mul);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = DATA_W'(base + k * mul);
      i_last  = (k == n - 1);
      step();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  int s0;
  int r0;
  int nz;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
    i_fc_result_valid = 1'b0; i_fc_result_data = '0; i_result_ready = 1'b1;
    step(); step();

    // Reset values
    check("rst_fc_start", o_fc_start, 0);
    check("rst_result_valid", o_result_valid, 0);
    check("rst_result_data", o_result_data, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_timeout", o_timeout, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", o_ready, 1);

    // Frame 1: k-112, launch, result after ~230 cycles
    s0 = start_cnt;
    send_frame(N_FEAT, -112, 1);
    check("f1_start_high", o_fc_start, 1);
    check("f1_start_count", start_cnt - s0, 1);
    check("f1_ready_low_launch", o_ready, 0);
    check("f1_buf0", flat[0], -112);
    check("f1_buf224", flat[224], 112);
    check("f1_buf100", flat[100], -12);
    step();
    check("f1_start_low_wait", o_fc_start, 0);
    check("f1_ready_low_wait", o_ready, 0);
    for (int c = 0; c < 228; c++) step();
    check("f1_no_result_yet", o_result_valid, 0);
    i_fc_result_valid = 1'b1;
    i_fc_result_data  = 48'sh0000_0012_3456;
    step();
    i_fc_result_valid = 1'b0;
    check("f1_result_valid", o_result_valid, 1);
    check("f1_result_data", o_result_data, 64'h12_3456);
    check("f1_ready_low_hold", o_ready, 0);
    step();
    check("f1_result_valid_drop", o_result_valid, 0);
    check("f1_ready_back", o_ready, 1);
    check("f1_single_start", start_cnt - s0, 1);

    // Short frame: i_last on index 100
    s0 = start_cnt;
    send_frame(101, 0, 1);
    check("ferr_pulse", o_frame_err, 1);
    check("ferr_ready", o_ready, 1);
    step();
    check("ferr_pulse_end", o_frame_err, 0);
    check("ferr_no_start", start_cnt - s0, 0);

    // Following full frame must start at index 0
    send_frame(N_FEAT, 0, 3);
    check("f3_start_high", o_fc_start, 1);
    check("f3_buf0", flat[0], 0);
    check("f3_buf1", flat[1], 3);
    check("f3_buf224", flat[224], 672);

    // No FC response: timeout
    r0 = rv_cnt;
    step();
    check("to_in_wait", o_ready, 0);
    for (int c = 0; c < TIMEOUT; c++) step();
    check("to_not_early", o_timeout, 0);
    check("to_ready_before", o_ready, 0);
    step();
    check("to_pulse", o_timeout, 1);
    check("to_ready_after", o_ready, 1);
    step();
    check("to_pulse_end", o_timeout, 0);
    check("to_no_result", rv_cnt - r0, 0);

    // Back-pressure in HOLD with i_valid driven during WAIT/HOLD
    send_frame(N_FEAT, 5, 1);
    check("f5_start_high", o_fc_start, 1);
    i_valid = 1'b1; i_data = -7; i_result_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("f5_wait_buf0", flat[0], 5);
    i_fc_result_valid = 1'b1;
    i_fc_result_data  = -48'sd5;
    step();
    i_fc_result_valid = 1'b0;
    i_fc_result_data  = 48'sd99;
    nz = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_result_valid !== 1'b1 || o_result_data !== -48'sd5 || o_ready !== 1'b0) nz++;
      step();
    end
    check("hold_stable_cycles", nz, 0);
    check("hold_valid", o_result_valid, 1);
    check("hold_data", o_result_data, -5);
    check("hold_buf0", flat[0], 5);
    check("hold_buf224", flat[224], 229);
    i_valid = 1'b0; i_result_ready = 1'b1;
    step();
    check("hold_release_valid", o_result_valid, 0);
    check("hold_release_ready", o_ready, 1);

    // Reset during WAIT
    send_frame(N_FEAT, 1, 1);
    for (int c = 0; c < 50; c++) step();
    check("rw_in_wait", o_ready, 0);
    rst = 1'b1;
    step();
    check("rw_ready", o_ready, 1);
    check("rw_fc_start", o_fc_start, 0);
    check("rw_result_valid", o_result_valid, 0);
    check("rw_result_data", o_result_data, 0);
    check("rw_frame_err", o_frame_err, 0);
    check("rw_timeout", o_timeout, 0);
    nz = 0;
    for (int i = 0; i < N_FEAT; i++) if (flat[i] !== '0) nz++;
    check("rw_buffer_zero", nz, 0);
    rst = 1'b0;
    i_fc_result_valid = 1'b1;
    i_fc_result_data  = 48'sd77;
    step();
    i_fc_result_valid = 1'b0;
    check("rw_late_result_ignored", o_result_valid, 0);
    step();
    check("rw_late_result_data", o_result_data, 0);
    check("rw_ready_after", o_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
